// File: rtl/reg_wr_arbiter.sv
// Write-port sequencer for the 8-bit register file: zero-fills every register after reset,
// then grants one writeback requester per cycle round-robin through a registered output stage.
module reg_wr_arbiter #(
  parameter int pw   = 3,
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_imm,
  input  logic [NREQ*pw-1:0] req_addr,
  input  logic [NREQ*8-1:0]  req_dat,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_wr_en,
  output logic               rf_alusrc,
  output logic [pw-1:0]      rf_wr_addr,
  output logic [7:0]         rf_dat,
  output logic [7:0]         rf_immed,
  output logic               pend_valid,
  output logic [pw-1:0]      pend_addr,
  output logic               init_done
);

  localparam int              RW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [RW:0]     NREQ_W   = (RW+1)'(NREQ);
  localparam logic [RW-1:0]   LAST_IDX = RW'(NREQ - 1);
  localparam logic [pw-1:0]   CNT_LAST = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [pw-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rr_q, rr_d;
  logic            wr_en_q, wr_en_d;
  logic            alusrc_q, alusrc_d;
  logic [pw-1:0]   addr_q, addr_d;
  logic [7:0]      dat_q, dat_d;
  logic [7:0]      immed_q, immed_d;
  logic            pv_q, pv_d;
  logic [pw-1:0]   paddr_q, paddr_d;
  logic            init_q, init_d;

  logic [NREQ-1:0] grant;
  logic [RW-1:0]   gidx;
  logic            found;
  logic [RW:0]     sum;
  logic [pw-1:0]   sel_addr;
  logic [7:0]      sel_dat;

  // Round-robin scan starting at rr_q; only the first valid requester is granted.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    if (state_q == RUN && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr_q} + k[RW:0];
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        if (!found && req_valid[sum[RW-1:0]]) begin
          found                = 1'b1;
          grant[sum[RW-1:0]]   = 1'b1;
          gidx                 = sum[RW-1:0];
        end
      end
    end
  end

  assign sel_addr  = req_addr[int'(gidx)*pw +: pw];
  assign sel_dat   = req_dat[int'(gidx)*8 +: 8];
  assign req_ready = grant;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    wr_en_d  = 1'b0;
    alusrc_d = 1'b0;
    addr_d   = addr_q;
    dat_d    = dat_q;
    immed_d  = immed_q;
    pv_d     = 1'b0;
    paddr_d  = paddr_q;
    init_d   = init_q | (state_q == RUN);
    case (state_q)
      CLEAR: begin
        wr_en_d = 1'b1;
        addr_d  = cnt_q;
        dat_d   = 8'h00;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = RUN;
      end
      RUN: begin
        if (found) begin
          wr_en_d = 1'b1;
          pv_d    = 1'b1;
          rr_d    = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
          if (req_imm[gidx]) begin
            // Immediate loads always target r0 through the ALUSrc path; dat_in is left alone.
            alusrc_d = 1'b1;
            immed_d  = sel_dat;
            addr_d   = '0;
            paddr_d  = '0;
          end else begin
            dat_d   = sel_dat;
            addr_d  = sel_addr;
            paddr_d = sel_addr;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      rr_q     <= '0;
      wr_en_q  <= 1'b0;
      alusrc_q <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      immed_q  <= '0;
      pv_q     <= 1'b0;
      paddr_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      wr_en_q  <= wr_en_d;
      alusrc_q <= alusrc_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      immed_q  <= immed_d;
      pv_q     <= pv_d;
      paddr_q  <= paddr_d;
      init_q   <= init_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_alusrc  = alusrc_q;
  assign rf_wr_addr = addr_q;
  assign rf_dat     = dat_q;
  assign rf_immed   = immed_q;
  assign pend_valid = pv_q;
  assign pend_addr  = paddr_q;
  assign init_done  = init_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter (pw=3, NREQ=3): clear sequence, grants, immediates,
// hold, and asynchronous reset in RUN.
module tb_reg_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hold;
  logic [2:0] req_valid, req_imm, req_ready;
  logic [8:0] req_addr;
  logic [23:0] req_dat;
  logic       rf_wr_en, rf_alusrc, pend_valid, init_done;
  logic [2:0] rf_wr_addr, pend_addr;
  logic [7:0] rf_dat, rf_immed;

  int checks = 0;
  int errors = 0;

  reg_wr_arbiter #(.pw(3), .NREQ(3)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_imm(req_imm), .req_addr(req_addr), .req_dat(req_dat),
    .req_ready(req_ready), .rf_wr_en(rf_wr_en), .rf_alusrc(rf_alusrc),
    .rf_wr_addr(rf_wr_addr), .rf_dat(rf_dat), .rf_immed(rf_immed),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq(input string pfx);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({pfx, "_wr_en"}, 32'(rf_wr_en), 32'd1);
      check({pfx, "_addr"}, 32'(rf_wr_addr), 32'(i));
      check({pfx, "_dat"}, 32'(rf_dat), 32'd0);
      check({pfx, "_init"}, 32'(init_done), 32'd0);
      if (i < 7) check({pfx, "_ready"}, 32'(req_ready), 32'd0);
      if (i == 6) req_valid = 3'b000;
    end
    tick();
    check({pfx, "_end_wr_en"}, 32'(rf_wr_en), 32'd0);
    check({pfx, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    hold      = 1'b0;
    req_valid = 3'b111;
    req_imm   = 3'b000;
    req_addr  = '0;
    req_dat   = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_pend", 32'(pend_valid), 32'd0);
    check("rst_init", 32'(init_done), 32'd0);
    check("rst_addr", 32'(rf_wr_addr), 32'd0);
    tick();
    reset = 1'b0;

    clear_seq("clr1");

    // Single requester 1, normal write
    req_valid = 3'b010;
    req_addr  = {3'd0, 3'd5, 3'd0};
    req_dat   = {8'h00, 8'hA7, 8'h00};
    #1 check("single_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = 3'b000;
    check("single_wr_en", 32'(rf_wr_en), 32'd1);
    check("single_addr", 32'(rf_wr_addr), 32'd5);
    check("single_dat", 32'(rf_dat), 32'hA7);
    check("single_alusrc", 32'(rf_alusrc), 32'd0);
    check("single_pv", 32'(pend_valid), 32'd1);
    check("single_paddr", 32'(pend_addr), 32'd5);
    tick();
    check("single_idle_wr_en", 32'(rf_wr_en), 32'd0);
    check("single_idle_pv", 32'(pend_valid), 32'd0);
    check("single_idle_addr_hold", 32'(rf_wr_addr), 32'd5);

    // Requester 2 immediate load (rr now points at 2)
    req_valid = 3'b100;
    req_imm   = 3'b100;
    req_addr  = {3'd6, 3'd0, 3'd0};
    req_dat   = {8'h3C, 16'h0000};
    #1 check("imm_ready", 32'(req_ready), 32'b100);
    tick();
    check("imm_wr_en", 32'(rf_wr_en), 32'd1);
    check("imm_alusrc", 32'(rf_alusrc), 32'd1);
    check("imm_immed", 32'(rf_immed), 32'h3C);
    check("imm_addr", 32'(rf_wr_addr), 32'd0);
    check("imm_paddr", 32'(pend_addr), 32'd0);
    check("imm_dat_hold", 32'(rf_dat), 32'hA7);

    // All three valid from rr=0: grants 0,1,2,0,1,2
    req_valid = 3'b111;
    req_imm   = 3'b000;
    req_addr  = {3'd3, 3'd2, 3'd1};
    req_dat   = {8'h33, 8'h22, 8'h11};
    for (int j = 0; j < 6; j++) begin
      #1 check("rr_ready", 32'(req_ready), 32'(1 << (j % 3)));
      tick();
      check("rr_wr_en", 32'(rf_wr_en), 32'd1);
      check("rr_addr", 32'(rf_wr_addr), 32'((j % 3) + 1));
      check("rr_dat", 32'(rf_dat), 32'(8'h11 * ((j % 3) + 1)));
    end

    // hold for 3 cycles; the in-flight write (requester 2) is already on the outputs
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1 check("hold_ready", 32'(req_ready), 32'd0);
      tick();
      check("hold_wr_en", 32'(rf_wr_en), 32'd0);
    end
    hold = 1'b0;
    #1 check("resume_ready", 32'(req_ready), 32'b001);
    tick();
    check("resume_wr_en", 32'(rf_wr_en), 32'd1);
    check("resume_addr", 32'(rf_wr_addr), 32'd1);
    check("resume_dat", 32'(rf_dat), 32'h11);

    // Asynchronous reset in RUN while a write is in the output stage
    reset = 1'b1;
    #1;
    check("arst_wr_en", 32'(rf_wr_en), 32'd0);
    check("arst_addr", 32'(rf_wr_addr), 32'd0);
    check("arst_dat", 32'(rf_dat), 32'd0);
    check("arst_pv", 32'(pend_valid), 32'd0);
    check("arst_init", 32'(init_done), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    #1 reset = 1'b0;

    clear_seq("clr2");

    req_valid = 3'b100;
    req_addr  = {3'd3, 3'd0, 3'd0};
    req_dat   = {8'h5A, 16'h0000};
    #1 check("post_clr_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = 3'b000;
    check("post_clr_addr", 32'(rf_wr_addr), 32'd3);
    check("post_clr_dat", 32'(rf_dat), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
